rf_seq_ctrl: RTL and testbench
==============================

// Module: rf_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer driving the 4-entry register file of the custom processor: fetches
//  8-bit instructions from a synchronous instruction ROM and issues reg-file reads (rs1/rs2)
//  and writes (rd/WE/WD). Implements ADD/SUB/JNZ/HALT; sits between the imem and reg file.
// PARAMETERS
//  WIDTH   16  data width; matches the reg file
//  ADDR_W  4   PC / imem address width (16-entry program)
// PORTS
//  clk          in   1       system clock; all state updates on posedge
//  rst          in   1       synchronous, active-high reset
//  start        in   1       1-cycle pulse; leaves IDLE or HALTED and runs from PC=0
//  imem_addr    out  ADDR_W  instruction address (=pc)
//  imem_rdata   in   8       instruction; valid 1 cycle after imem_addr
//  rf_rs1       out  2       reg-file read select 1 (=IR[3:2])
//  rf_rs2       out  2       reg-file read select 2 (=IR[1:0])
//  rf_rd        out  2       reg-file write select (=IR[5:4])
//  rf_we        out  1       reg-file write enable
//  rf_wd        out  WIDTH   reg-file write data (=result register)
//  rf_rs1_data  in   WIDTH   combinational read data for rf_rs1
//  rf_rs2_data  in   WIDTH   combinational read data for rf_rs2
//  busy         out  1       high in FETCH/DECODE/EXEC/WB
//  halted       out  1       high in HALTED
//  pc           out  ADDR_W  current program counter
// BEHAVIOUR
//  Reset (sync, highest priority; aborts any operation): state=IDLE, pc=0, IR=0, result=0,
//   rf_we=0, busy=0, halted=0. A reset asserted in WB suppresses that write.
//  ISA: IR[7:6] op, [5:4] rd, [3:2] rs1, [1:0] rs2.
//   00 ADD rd=rs1+rs2 | 01 SUB rd=rs1-rs2 | 10 JNZ: if R[rs1]!=0 pc={IR[5:4],IR[1:0]}
//   (absolute, ADDR_W=4) else pc+1 | 11 HALT.
//  FSM:
//   IDLE   -> FETCH on start (pc<=0); otherwise hold
//   FETCH  imem_addr=pc -> DECODE
//   DECODE IR<=imem_rdata -> EXEC
//   EXEC   ADD/SUB: result<=ALU(rf_rs1_data,rf_rs2_data) -> WB
//          JNZ: update pc as above -> FETCH
//          HALT: pc unchanged -> HALTED
//   WB     rf_we=1 for exactly this cycle unless rd==0 (then 0); pc<=pc+1 -> FETCH
//   HALTED hold; start -> FETCH with pc<=0, IR<=0
//  Latency: ADD/SUB 4 cycles, JNZ 3, HALT 3 to halted=1.
//  Arithmetic modulo 2^WIDTH, no flags (0xFFFF+1=0, 0-1=0xFFFF).
//  pc increment wraps 2^ADDR_W-1 -> 0.
//  rf_we is a registered/state decode: never high outside WB; rf_wd stable through WB.
//  start ignored while busy.
//  rf_rs1/rf_rs2/rf_rd follow IR at all times; reg-file reads are combinational, so EXEC
//   samples valid data in the same cycle.
//  R0 reads as 0 (reg-file guarantee); writes to R0 are never issued.
// TESTING
//  Fib: R1=1,R2=1 preloaded; prog ADD R3,R1,R2; ADD R1,R2,R0; ADD R2,R3,R0; JNZ R3->0
//   -> after 3 loops R3=2,3,5 seen on rf_wd in WB cycles, rf_we 1 cycle each.
//  Wrap: R1=0xFFFF,R2=1, ADD R3,R1,R2 -> rf_wd=0x0000; SUB R3,R0,R2 -> 0xFFFF.
//  R0 dest: ADD R0,R1,R2 -> rf_we stays 0 all 4 cycles; pc increments by 1.
//  JNZ: R1=0 -> pc+1 after 3 cycles; R1=5, target 0xA -> pc=0xA; HALT -> halted=1, busy=0.
//  Reset in WB -> rf_we=0 that cycle, state IDLE, pc=0; start during busy has no effect.
//  PC wrap: ADD at addr 0xF -> next fetch at imem_addr=0x0.

Source files
------------

// File: rtl/rf_seq_if.sv
// Sequencer-side bundle: instruction memory fetch port plus register-file read/write port.
interface rf_seq_if #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
);
    logic [ADDR_W-1:0] imem_addr;
    logic [7:0]        imem_rdata;
    logic [1:0]        rf_rs1;
    logic [1:0]        rf_rs2;
    logic [1:0]        rf_rd;
    logic              rf_we;
    logic [WIDTH-1:0]  rf_wd;
    logic [WIDTH-1:0]  rf_rs1_data;
    logic [WIDTH-1:0]  rf_rs2_data;

    modport master (
        output imem_addr, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wd,
        input  imem_rdata, rf_rs1_data, rf_rs2_data
    );

    modport slave (
        input  imem_addr, rf_rs1, rf_rs2, rf_rd, rf_we, rf_wd,
        output imem_rdata, rf_rs1_data, rf_rs2_data
    );
endinterface

// File: rtl/rf_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for a 4-entry register file.
// ISA: ADD, SUB, JNZ (absolute target), HALT; one 8-bit instruction per imem word.
module rf_seq_ctrl #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    rf_seq_if.master          bus,
    output logic              busy,
    output logic              halted,
    output logic [ADDR_W-1:0] pc
);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StExec, StWb, StHalted
    } state_e;

    typedef enum logic [1:0] {OpAdd, OpSub, OpJnz, OpHalt} op_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        ir_q, ir_d;
    logic [WIDTH-1:0]  result_q, result_d;
    op_e               op;
    logic [ADDR_W-1:0] jnz_target;

    assign op         = op_e'(ir_q[7:6]);
    assign jnz_target = ADDR_W'({ir_q[5:4], ir_q[1:0]});

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            ir_q     <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        result_d = result_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                end
            end
            StFetch:  state_d = StDecode;
            StDecode: begin
                ir_d    = bus.imem_rdata;
                state_d = StExec;
            end
            StExec: begin
                unique case (op)
                    OpAdd: begin
                        result_d = bus.rf_rs1_data + bus.rf_rs2_data;
                        state_d  = StWb;
                    end
                    OpSub: begin
                        result_d = bus.rf_rs1_data - bus.rf_rs2_data;
                        state_d  = StWb;
                    end
                    OpJnz: begin
                        pc_d    = (bus.rf_rs1_data != '0) ? jnz_target : pc_q + ADDR_W'(1);
                        state_d = StFetch;
                    end
                    OpHalt: state_d = StHalted;
                endcase
            end
            StWb: begin
                pc_d    = pc_q + ADDR_W'(1);
                state_d = StFetch;
            end
            StHalted: begin
                if (start) begin
                    state_d = StFetch;
                    pc_d    = '0;
                    ir_d    = '0;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Reset gates the write combinationally so a reset landing in WB drops that write.
    assign bus.rf_we     = (state_q == StWb) && (ir_q[5:4] != 2'd0) && !rst;
    assign bus.rf_wd     = result_q;
    assign bus.rf_rd     = ir_q[5:4];
    assign bus.rf_rs1    = ir_q[3:2];
    assign bus.rf_rs2    = ir_q[1:0];
    assign bus.imem_addr = pc_q;

    assign busy   = (state_q == StFetch) || (state_q == StDecode) ||
                    (state_q == StExec)  || (state_q == StWb);
    assign halted = (state_q == StHalted);
    assign pc     = pc_q;

endmodule

// File: tb/tb_rf_seq_ctrl.sv
// Bench for rf_seq_ctrl: behavioural ROM and register file around the DUT, plus an
// instruction-level ISA model that predicts writes, PC flow and halting.
module tb_rf_seq_ctrl;
    localparam int unsigned WIDTH  = 16;
    localparam int unsigned ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              halted;
    logic [ADDR_W-1:0] pc;

    rf_seq_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

    rf_seq_ctrl #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (bus),
        .busy   (busy),
        .halted (halted),
        .pc     (pc)
    );

    always #5 clk = ~clk;

    // Environment: synchronous ROM and a register file with R0 hardwired to zero.
    logic [7:0]       rom [16];
    logic [WIDTH-1:0] rf [4];
    logic [WIDTH-1:0] ld_val [4];
    logic             ld;

    always @(posedge clk) bus.imem_rdata <= rom[bus.imem_addr];

    always_comb begin
        bus.rf_rs1_data = (bus.rf_rs1 == 2'd0) ? '0 : rf[bus.rf_rs1];
        bus.rf_rs2_data = (bus.rf_rs2 == 2'd0) ? '0 : rf[bus.rf_rs2];
    end

    always @(posedge clk) begin
        if (ld) begin
            for (int i = 0; i < 4; i++) rf[i] <= ld_val[i];
        end else if (bus.rf_we) begin
            rf[bus.rf_rd] <= bus.rf_wd;
        end
    end

    // ISA model state
    logic [WIDTH-1:0]  m_r [4];
    logic [ADDR_W-1:0] m_pc;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = 8'hC0;
    endtask

    task automatic load(input logic [WIDTH-1:0] r1, input logic [WIDTH-1:0] r2,
                        input logic [WIDTH-1:0] r3);
        ld_val[0] = '0; ld_val[1] = r1; ld_val[2] = r2; ld_val[3] = r3;
        for (int i = 0; i < 4; i++) m_r[i] = ld_val[i];
        ld = 1'b1;
        step();
        ld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_busy", busy, 0);
        check("rst_halted", halted, 0);
        check("rst_pc", pc, 0);
        check("rst_we", bus.rf_we, 0);
    endtask

    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        m_pc = '0;
    endtask

    task automatic check_regs();
        for (int i = 0; i < 4; i++) check($sformatf("reg%0d", i), rf[i], m_r[i]);
    endtask

    // Entered with the DUT in its fetch cycle; leaves it in the next fetch cycle or halted.
    task automatic run_instr(output bit hit_halt, input bit poke);
        logic [7:0]       ir;
        logic [1:0]       rd, rs1, rs2;
        logic [WIDTH-1:0] res;
        hit_halt = 1'b0;
        ir  = rom[m_pc];
        rd  = ir[5:4];
        rs1 = ir[3:2];
        rs2 = ir[1:0];
        check("fetch_addr", bus.imem_addr, m_pc);
        check("fetch_busy", busy, 1);
        check("fetch_we", bus.rf_we, 0);
        step();
        check("dec_we", bus.rf_we, 0);
        if (poke) start = 1'($urandom_range(0, 1));
        step();
        start = 1'b0;
        check("exec_we", bus.rf_we, 0);
        case (ir[7:6])
            2'd0, 2'd1: begin
                res = (ir[7:6] == 2'd0) ? m_r[rs1] + m_r[rs2] : m_r[rs1] - m_r[rs2];
                step();
                check("wb_we", bus.rf_we, {31'd0, rd != 2'd0});
                if (rd != 2'd0) begin
                    check("wb_wd", bus.rf_wd, res);
                    check("wb_rd", bus.rf_rd, rd);
                    m_r[rd] = res;
                end
                m_pc = m_pc + 1'b1;
                step();
            end
            2'd2: begin
                m_pc = (m_r[rs1] != '0) ? {rd, rs2} : m_pc + 1'b1;
                step();
            end
            default: begin
                step();
                check("halt_halted", halted, 1);
                check("halt_busy", busy, 0);
                check("halt_pc", pc, m_pc);
                hit_halt = 1'b1;
            end
        endcase
    endtask

    task automatic run(input int n, input bit poke);
        bit h;
        for (int k = 0; k < n; k++) begin
            run_instr(h, poke);
            if (h) break;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        ld    = 1'b0;
        for (int i = 0; i < 4; i++) ld_val[i] = '0;
        clear_rom();
        step();
        step();
        rst = 1'b0;
        check("init_busy", busy, 0);
        check("init_halted", halted, 0);
        check("init_pc", pc, 0);
        check("init_we", bus.rf_we, 0);

        // Fibonacci loop, three passes
        clear_rom();
        rom[0] = 8'h36; rom[1] = 8'h18; rom[2] = 8'h2C; rom[3] = 8'h8C;
        load(16'd1, 16'd1, 16'd0);
        start_run();
        run(12, 1'b0);
        check("fib_r1", rf[1], 16'd3);
        check("fib_r2", rf[2], 16'd5);
        check("fib_r3", rf[3], 16'd5);
        do_reset();

        // Modular wrap on ADD and SUB
        clear_rom();
        rom[0] = 8'h36; rom[1] = 8'h72;
        load(16'hFFFF, 16'd1, 16'd7);
        start_run();
        run(10, 1'b0);
        check("wrap_r3", rf[3], 16'hFFFF);
        check_regs();
        do_reset();

        // R0 destination, JNZ not-taken then taken to 0xA, halt, restart from halted
        clear_rom();
        rom[0] = 8'h06; rom[1] = 8'hBB; rom[2] = 8'hA6;
        load(16'd5, 16'd0, 16'd0);
        start_run();
        run(10, 1'b0);
        check("jnz_pc", pc, 4'hA);
        start_run();
        run(1, 1'b0);
        check_regs();
        do_reset();

        // PC wrap after ADD at 0xF
        clear_rom();
        rom[0] = 8'hB7; rom[15] = 8'h35;
        load(16'd5, 16'd0, 16'd0);
        start_run();
        run(4, 1'b0);
        check_regs();
        do_reset();

        // Reset landing in writeback drops the write
        clear_rom();
        rom[0] = 8'h36;
        load(16'd2, 16'd3, 16'h1234);
        start_run();
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        check("rstwb_we", bus.rf_we, 0);
        step();
        rst = 1'b0;
        check("rstwb_busy", busy, 0);
        check("rstwb_pc", pc, 0);
        step();
        check("rstwb_idle", busy, 0);
        check("rstwb_r3", rf[3], 16'h1234);

        // Random programs, with start poked while busy
        for (int t = 0; t < 20; t++) begin
            do_reset();
            for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
            load(16'($urandom), 16'($urandom), 16'($urandom));
            start_run();
            run(30, 1'b1);
            check_regs();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
